// File: rtl/top_serial_pkg.sv
// top_serial_pkg: shared timing defaults, init FSM encoding, colour bar
// table and the panel configuration ROM for top_serial.
package top_serial_pkg;

    // Default panel timing (pixel clocks per line, lines per frame)
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_H_FP     = 20;
    localparam int DEF_H_SYNC_W = 30;
    localparam int DEF_H_BP     = 38;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC_W = 3;
    localparam int DEF_V_BP     = 15;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC_W + DEF_H_BP; // 408
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC_W + DEF_V_BP; // 262

    // Init FSM state encoding
    typedef logic [2:0] init_state_t;
    localparam init_state_t ST_WAIT  = 3'd0;
    localparam init_state_t ST_LOAD  = 3'd1;
    localparam init_state_t ST_SHIFT = 3'd2;
    localparam init_state_t ST_GAP   = 3'd3;
    localparam init_state_t ST_DONE  = 3'd4;

    // Colour bars, left to right; entry 0 is the leftmost bar
    localparam logic [7:0][7:0] BAR_COLOR = {
        8'h00, 8'hE3, 8'h1F, 8'hFC, 8'h03, 8'h1C, 8'hE0, 8'hFF
    };

    // Panel register writes, sent in index order 0..7
    localparam logic [7:0][15:0] INIT_ROM = {
        16'h0A03, 16'h2008, 16'h1F00, 16'h1E00,
        16'h0D10, 16'h0C40, 16'h0B00, 16'h0A01
    };

    // True when v lies in [lo, lo+w)
    function automatic logic in_window(input int v, input int lo, input int w);
        return (v >= lo) && (v < lo + w);
    endfunction

endpackage

// File: rtl/top_serial_spi.sv
// top_serial_spi: 3-wire serial shifter. One 16-bit word per load strobe,
// MSB first. SPDA changes on SPCLK falling, sampled by the panel on rising.
// Frame: SPENB low, half period, 16 fall/rise pairs, half period, SPENB high.
module top_serial_spi #(
    parameter int SPI_DIV = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] word_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        spda_o,
    output logic        spclk_o,
    output logic        spenb_o
);

    localparam int HALF = SPI_DIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [HW-1:0] hc_q;     // cycles within the current half period
    logic [5:0]    ph_q;     // half-period index within the frame, 0..33
    logic [15:0]   sh_q;
    logic          busy_q, done_q, spda_q, spclk_q, spenb_q;
    logic          half_end;

    assign half_end = (hc_q == HW'(HALF - 1));

    // Frame sequencer: even->odd phase is a falling edge (new bit), odd->even
    // a rising edge, and leaving phase 32 releases SPENB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hc_q    <= '0;
            ph_q    <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            spda_q  <= 1'b0;
            spclk_q <= 1'b1;
            spenb_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (load_i) begin
                    busy_q  <= 1'b1;
                    spenb_q <= 1'b0;
                    sh_q    <= word_i;
                    hc_q    <= '0;
                    ph_q    <= '0;
                end
            end else if (half_end) begin
                hc_q <= '0;
                ph_q <= ph_q + 6'd1;
                if (ph_q == 6'd32) begin
                    spenb_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (!ph_q[0]) begin
                    spclk_q <= 1'b0;
                    spda_q  <= sh_q[15];
                    sh_q    <= {sh_q[14:0], 1'b0};
                end else begin
                    spclk_q <= 1'b1;
                end
            end else begin
                hc_q <= hc_q + HW'(1);
            end
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign spda_o  = spda_q;
    assign spclk_o = spclk_q;
    assign spenb_o = spenb_q;

endmodule

// File: rtl/top_serial.sv
// top_serial: small RGB panel driver. After a power-up wait it writes eight
// configuration words over a 3-wire serial link, then runs the video timing.
// Build option: define TOPSERIAL_COLORBAR_EN for an 8-bar test pattern;
// otherwise active pixels show hcnt[7:0].
module top_serial
    import top_serial_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SPI_DIV  = 16,
    parameter int PWR_WAIT = 1000,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC_W = DEF_H_SYNC_W,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC_W = DEF_V_SYNC_W,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic       CLKIN,
    output logic       H_SYNC,
    output logic       V_SYNC,
    output logic       SPDA,
    output logic       SPCLK,
    output logic       SPENB,
    output logic [7:0] dataLCD,
    output logic       led
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
    localparam int HCW   = $clog2(H_TOT);
    localparam int VCW   = $clog2(V_TOT);
    localparam int CW    = $clog2(CLK_DIV);
    localparam int TMAX  = (PWR_WAIT > SPI_DIV) ? PWR_WAIT : SPI_DIV;
    localparam int TW    = $clog2(TMAX + 1);

    // ---------------- pixel clock ----------------
    logic [CW-1:0] div_q;
    logic          clkin_q;
    logic          pix_tick;     // sys_clk edge on which CLKIN falls

    assign pix_tick = (div_q == CW'(CLK_DIV - 1));

    // Divide sys_clk; CLKIN rises mid-period and falls on the wrap
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q   <= '0;
            clkin_q <= 1'b0;
        end else begin
            div_q <= pix_tick ? '0 : div_q + CW'(1);
            if (div_q == CW'(CLK_DIV / 2 - 1)) clkin_q <= 1'b1;
            else if (pix_tick)                  clkin_q <= 1'b0;
        end
    end

    // ---------------- init sequencer ----------------
    init_state_t   st_q, st_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          led_q, led_d;
    logic          spi_load, spi_busy, spi_done;

    // Next-state: power wait, then load/shift/gap for each ROM word
    always_comb begin
        st_d     = st_q;
        tcnt_d   = tcnt_q;
        idx_d    = idx_q;
        led_d    = led_q;
        spi_load = 1'b0;
        case (st_q)
            ST_WAIT: begin
                if (tcnt_q == TW'(PWR_WAIT - 1)) begin
                    tcnt_d = '0;
                    st_d   = ST_LOAD;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_LOAD: begin
                // never strobe a shifter that is still mid-frame
                if (!spi_busy) begin
                    spi_load = 1'b1;
                    st_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: if (spi_done) st_d = ST_GAP;
            ST_GAP: begin
                if (tcnt_q == TW'(SPI_DIV - 1)) begin
                    tcnt_d = '0;
                    if (idx_q == 3'd7) begin
                        st_d  = ST_DONE;
                        led_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        st_d  = ST_LOAD;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_DONE: ;
            default: st_d = ST_WAIT;
        endcase
    end

    // Init sequencer state registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st_q   <= ST_WAIT;
            tcnt_q <= '0;
            idx_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            tcnt_q <= tcnt_d;
            idx_q  <= idx_d;
            led_q  <= led_d;
        end
    end

    top_serial_spi #(.SPI_DIV(SPI_DIV)) u_spi (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .load_i  (spi_load),
        .word_i  (INIT_ROM[idx_q]),
        .busy_o  (spi_busy),
        .done_o  (spi_done),
        .spda_o  (SPDA),
        .spclk_o (SPCLK),
        .spenb_o (SPENB)
    );

    // ---------------- video timing ----------------
    logic [HCW-1:0] hcnt_q;
    logic [VCW-1:0] vcnt_q;
    logic           hs_q, vs_q;
    logic [7:0]     data_q, pix_d;
`ifdef TOPSERIAL_COLORBAR_EN
    int             bar;
`endif

    // Pixel value for the current counters; black in blanking
    always_comb begin
        pix_d = 8'h00;
`ifdef TOPSERIAL_COLORBAR_EN
        bar = 0;
`endif
        if (int'(hcnt_q) < H_ACTIVE && int'(vcnt_q) < V_ACTIVE) begin
`ifdef TOPSERIAL_COLORBAR_EN
            bar = int'(hcnt_q) / (H_ACTIVE / 8);
            if (bar > 7) bar = 7;
            pix_d = BAR_COLOR[3'(bar)];
`else
            pix_d = 8'(hcnt_q);
`endif
        end
    end

    // Counters and registered outputs advance on each pixel tick once init is done
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            data_q <= 8'h00;
        end else if (pix_tick && st_q == ST_DONE) begin
            hs_q   <= !in_window(int'(hcnt_q), H_ACTIVE + H_FP, H_SYNC_W);
            vs_q   <= !in_window(int'(vcnt_q), V_ACTIVE + V_FP, V_SYNC_W);
            data_q <= pix_d;
            if (hcnt_q == HCW'(H_TOT - 1)) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == VCW'(V_TOT - 1)) ? '0 : vcnt_q + VCW'(1);
            end else begin
                hcnt_q <= hcnt_q + HCW'(1);
            end
        end
    end

    assign CLKIN   = clkin_q;
    assign H_SYNC  = hs_q;
    assign V_SYNC  = vs_q;
    assign dataLCD = data_q;
    assign led     = led_q;

endmodule

// File: tb/tb_top_serial.sv
// tb_top_serial: scoreboard bench for top_serial. Expected serial words and
// selected pixel samples are queued when stimulus is issued; monitors pop and
// compare as the DUT presents them. Vertical timing is shortened so whole
// frames fit in a short run; horizontal timing keeps its defaults.
module tb_top_serial;

    localparam int HT = 408;   // 320+20+30+38
    localparam int VT = 9;     // 4+1+3+1

    logic       sys_clk, sys_rst;
    logic       CLKIN, H_SYNC, V_SYNC, SPDA, SPCLK, SPENB, led;
    logic [7:0] dataLCD;

    top_serial #(
        .CLK_DIV(4), .SPI_DIV(16), .PWR_WAIT(1000),
        .H_ACTIVE(320), .H_FP(20), .H_SYNC_W(30), .H_BP(38),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC_W(3), .V_BP(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .CLKIN(CLKIN),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .SPDA(SPDA), .SPCLK(SPCLK),
        .SPENB(SPENB), .dataLCD(dataLCD), .led(led)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int         p;
        logic [7:0] d;
        logic       hs;
        logic       vs;
    } pix_vec_t;

    int          tests = 0, fails = 0;
    logic [15:0] spi_q[$];
    pix_vec_t    pix_q[$];
    int          words_done = 0;
    int          nbits = 0;
    logic [15:0] word_sh = '0;
    int          pix_idx = 0;
    int          blank_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_CLKIN"},   32'(CLKIN),   32'd0);
        check({tag, "_H_SYNC"},  32'(H_SYNC),  32'd1);
        check({tag, "_V_SYNC"},  32'(V_SYNC),  32'd1);
        check({tag, "_SPENB"},   32'(SPENB),   32'd1);
        check({tag, "_SPCLK"},   32'(SPCLK),   32'd1);
        check({tag, "_SPDA"},    32'(SPDA),    32'd0);
        check({tag, "_dataLCD"}, 32'(dataLCD), 32'd0);
        check({tag, "_led"},     32'(led),     32'd0);
    endtask

    task automatic push_words();
        spi_q.push_back(16'h0A01); spi_q.push_back(16'h0B00);
        spi_q.push_back(16'h0C40); spi_q.push_back(16'h0D10);
        spi_q.push_back(16'h1E00); spi_q.push_back(16'h1F00);
        spi_q.push_back(16'h2008); spi_q.push_back(16'h0A03);
    endtask

    task automatic pv(input int p, input logic [7:0] d, input logic hs, input logic vs);
        pix_vec_t v;
        v.p = p; v.d = d; v.hs = hs; v.vs = vs;
        pix_q.push_back(v);
    endtask

    task automatic push_pixels();
`ifdef TOPSERIAL_COLORBAR_EN
        pv(0, 8'hFF, 1, 1);   pv(5, 8'hFF, 1, 1);   pv(40, 8'hE0, 1, 1);
        pv(80, 8'h1C, 1, 1);  pv(120, 8'h03, 1, 1); pv(300, 8'h00, 1, 1);
        pv(319, 8'h00, 1, 1);
`else
        pv(0, 8'h00, 1, 1);   pv(5, 8'h05, 1, 1);   pv(40, 8'h28, 1, 1);
        pv(80, 8'h50, 1, 1);  pv(120, 8'h78, 1, 1); pv(300, 8'h2C, 1, 1);
        pv(319, 8'h3F, 1, 1);
`endif
        pv(320, 8'h00, 1, 1); pv(339, 8'h00, 1, 1); pv(340, 8'h00, 0, 1);
        pv(369, 8'h00, 0, 1); pv(370, 8'h00, 1, 1);
`ifdef TOPSERIAL_COLORBAR_EN
        pv(663, 8'hE3, 1, 1); pv(1424, 8'h1F, 1, 1);
`else
        pv(663, 8'hFF, 1, 1); pv(1424, 8'hC8, 1, 1);
`endif
        pv(1637, 8'h00, 1, 1); pv(2040, 8'h00, 1, 0);
        pv(3201, 8'h00, 0, 0); pv(3264, 8'h00, 1, 1);
    endtask

    // Cycles from reset release until SPENB first goes low
    task automatic measure_spenb_fall(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge sys_clk); #1;
            n++;
            if (!SPENB) break;
        end
        tests++;
        if (SPENB || n < 1000 || n > 1001) begin
            fails++;
            $display("FAIL %s: SPENB fell after %0d cycles, expected 1000..1001", name, n);
        end
    endtask

    // SPI monitor: shift in SPDA on SPCLK rising while enabled
    always @(negedge SPENB) begin
        nbits = 0;
        word_sh = '0;
    end

    always @(posedge SPCLK) begin
        if (!sys_rst && !SPENB) begin
            word_sh = {word_sh[14:0], SPDA};
            nbits++;
        end
    end

    always @(posedge SPENB) begin
        if (!sys_rst) begin
            if (spi_q.size() == 0) begin
                check("spi_unexpected_word", 32'(word_sh), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = spi_q.pop_front();
                check($sformatf("spi_word%0d", words_done), {nbits[15:0], word_sh}, {16'd16, e});
            end
            check($sformatf("led_low_word%0d", words_done), 32'(led), 32'd0);
            words_done++;
        end
    end

    // Pixel monitor: sample mid-pixel, starting with the first tick after led
    initial begin
        @(posedge led);
        #1;
        @(negedge CLKIN);
        forever begin
            @(posedge CLKIN); #1;
            if (pix_idx < HT * VT) begin
                if (((pix_idx % HT) >= 320 || (pix_idx / HT) >= 4) && dataLCD != 8'h00)
                    blank_bad++;
            end
            if (pix_q.size() > 0 && pix_q[0].p == pix_idx) begin
                pix_vec_t v;
                v = pix_q.pop_front();
                check($sformatf("pix%0d", v.p), {22'd0, H_SYNC, V_SYNC, dataLCD},
                      {22'd0, v.hs, v.vs, v.d});
            end
            pix_idx++;
        end
    end

    // Watchdog: an expired bound counts as a failure and still summarises
    initial begin
        #1600000;
        tests++;
        fails++;
        $display("FAIL watchdog: run exceeded time limit, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        time t0, t1, t2;
        sys_rst = 1'b1;
        #15;
        check_reset("por");
        #10;
        sys_rst = 1'b0;
        push_words();
        measure_spenb_fall("spenb_fall_1st");

        // reset in the middle of word 3
        for (int i = 0; i < 5000 && !(words_done == 3 && !SPENB); i++) @(posedge sys_clk);
        check("reach_word3", 32'(words_done == 3 && !SPENB), 32'd1);
        repeat (100) @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        #1 check_reset("midword");
        spi_q.delete();
        words_done = 0;
        repeat (4) @(posedge sys_clk);
        #5 sys_rst = 1'b0;
        push_words();
        push_pixels();
        measure_spenb_fall("spenb_fall_2nd");

        for (int i = 0; i < 10000 && !led; i++) begin
            @(posedge sys_clk); #1;
        end
        check("led_rise", 32'(led), 32'd1);
        check("words_at_led", 32'(words_done), 32'd8);
        check("spi_queue_drained", 32'(spi_q.size()), 32'd0);

        // CLKIN period: 4 sys_clk of 20 time units
        @(posedge CLKIN); t0 = $time;
        @(posedge CLKIN); t1 = $time;
        check("clkin_period", 32'(t1 - t0), 32'd80);

        // H_SYNC: 30 pixel clocks low, 1632 sys_clk period
        @(negedge H_SYNC); t0 = $time;
        @(posedge H_SYNC); t1 = $time;
        @(negedge H_SYNC); t2 = $time;
        check("hsync_low", 32'(t1 - t0), 32'd2400);
        check("hsync_period", 32'(t2 - t0), 32'd32640);

        // V_SYNC: 3 lines low, 9-line frame
        @(negedge V_SYNC); t0 = $time;
        @(posedge V_SYNC); t1 = $time;
        @(negedge V_SYNC); t2 = $time;
        check("vsync_low", 32'(t1 - t0), 32'd97920);
        check("vsync_period", 32'(t2 - t0), 32'd293760);

        for (int i = 0; i < 20000 && (pix_q.size() != 0 || pix_idx < HT * VT); i++)
            @(posedge sys_clk);
        check("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        check("blank_pixels_zero", 32'(blank_bad), 32'd0);
        check("led_stays_high", 32'(led), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top_serial.md
TOP_SERIAL -- requirements
Module: top_serial

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, sys_clk cycles per pixel clock (even, >=2).
REQ-002 SHALL have parameter SPI_DIV, default 16, sys_clk cycles per SPCLK period (even, >=4).
REQ-003 SHALL have parameter PWR_WAIT, default 1000, sys_clk cycles from reset release to first serial word.
REQ-004 SHALL have parameters H_ACTIVE 320, H_FP 20, H_SYNC_W 30, H_BP 38, in pixel clocks.
REQ-005 SHALL have parameters V_ACTIVE 240, V_FP 4, V_SYNC_W 3, V_BP 15, in lines.
REQ-006 sys_clk  input  1  system clock, 50 MHz; one clock domain only.
REQ-007 sys_rst  input  1  reset, asynchronous, active-high.
REQ-008 CLKIN  output  1  pixel clock to the panel.
REQ-009 H_SYNC  output  1  horizontal sync, active-low.
REQ-010 V_SYNC  output  1  vertical sync, active-low.
REQ-011 SPDA / SPCLK / SPENB  output  1 each  3-wire config serial data, clock (idle high), enable (active-low).
REQ-012 dataLCD  output  8  pixel data, RGB332.
REQ-013 led  output  1  high once panel initialisation is complete.

Function
REQ-014 CLKIN SHALL be sys_clk/CLK_DIV, 50% duty, running from reset release; all video outputs SHALL update on the sys_clk edge where CLKIN falls.
REQ-015 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL=408) per pixel clock; vcnt SHALL increment when hcnt wraps, range 0..V_TOTAL-1 (262), wrapping to 0.
REQ-016 Order per line/frame: active, front porch, sync, back porch; H_SYNC low iff hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC_W); V_SYNC likewise on vcnt.
REQ-017 dataLCD SHALL be 0 outside active region (hcnt>=H_ACTIVE or vcnt>=V_ACTIVE).
REQ-018 Init FSM states: WAIT -> LOAD -> SHIFT -> GAP -> (LOAD if more words, else DONE); DONE is terminal until reset.
REQ-019 WAIT SHALL last PWR_WAIT cycles; LOAD fetches INIT_ROM[idx], idx 0..7.
REQ-020 SHIFT: SPENB low; 16 bits MSB first; SPDA changes on SPCLK falling, stable at SPCLK rising; SPENB falls half an SPCLK period before first falling edge and rises half a period after last rising edge.
REQ-021 GAP: SPENB high, SPCLK high, for one full SPCLK period.
REQ-022 Video counters SHALL be held at 0 with H_SYNC=V_SYNC=1 and dataLCD=0 until DONE; first frame starts at hcnt=vcnt=0 on the first pixel tick in DONE.
REQ-023 led SHALL rise on entry to DONE and stay high.

Reset
REQ-024 On sys_rst=1, asynchronously: CLKIN=0, H_SYNC=1, V_SYNC=1, SPENB=1, SPCLK=1, SPDA=0, dataLCD=0, led=0, counters 0, FSM=WAIT, idx=0.
REQ-025 Reset mid-word SHALL abort the word; after release the sequence restarts at WAIT, word 0.

Configuration
REQ-026 Macro TOPSERIAL_COLORBAR_EN defined: active pixels show 8 bars of H_ACTIVE/8 pixels: FF,E0,1C,03,FC,1F,E3,00 (hex).
REQ-027 Macro undefined: active pixel value SHALL be hcnt[7:0].

Structure
REQ-028 Package top_serial_pkg SHALL hold timing defaults, H_TOTAL/V_TOTAL, FSM state enum, bar colour table, and INIT_ROM[8] = 0A01,0B00,0C40,0D10,1E00,1F00,2008,0A03 (hex).
REQ-029 Serial shifter SHALL be sub-module top_serial_spi (load strobe, 16-bit word in, busy/done out, SPDA/SPCLK/SPENB out).

Verification
REQ-030 Assert sys_rst mid-run -> all outputs take REQ-024 values without a clock edge.
REQ-031 Release reset -> SPENB falls after 1000 cycles; bits sampled on SPCLK rising = 16'h0A01; 8 words, led=1 after 8th SPENB rise.
REQ-032 After led=1 -> CLKIN period 80 ns; H_SYNC low 30 pixel clocks, period 1632 sys_clk cycles.
REQ-033 V_SYNC low 3 lines (1224 pixel clocks); frame 262 lines; dataLCD=0 on every blanking pixel.
REQ-034 With TOPSERIAL_COLORBAR_EN: pixel 0 = FF, pixel 40 = E0, pixel 319 = 00; without: pixel 5 = 05, pixel 300 = 2C (hex).
REQ-035 Reset during word 3 -> SPENB high at once; after release word 0x0A01 resent first, led stays 0 until all 8 words complete.
